// File: rtl/aliens_pkg.sv
// rtl/aliens_pkg.sv - shared FSM encoding and constants for the alien bomb logic
package aliens_pkg;

  typedef enum logic [1:0] {
    Sidle,
    Scooldown,
    Sselect,
    Sfalling
  } state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int NUM_COLUMNS            = 8;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 8'hA5
module lfsr8 (
  input  logic       clk,
  input  logic       resetN,
  output logic [7:0] value
);

  localparam logic [7:0] SEED = 8'hA5;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      value <= SEED;
    end else begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end

endmodule

// File: rtl/alien_bomb_controller.sv
// rtl/alien_bomb_controller.sv - picks a living formation column, drops one bomb, cools down
module alien_bomb_controller
  import aliens_pkg::*;
#(
  parameter int COOLDOWN_FRAMES  = 45,
  parameter int BOMB_SPEED       = 128,
  parameter int COLUMN_PITCH     = 56,
  parameter int BOMB_X_OFFSET    = 24,
  parameter int FORMATION_HEIGHT = 160,
  parameter int BOTTOM_BOUNDARY  = 479
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic signed [10:0] aliensTopLeftX,
  input  logic signed [10:0] aliensTopLeftY,
  input  logic        [7:0]  aliveColumns,
  input  logic               bombHit,
  output logic signed [10:0] bombTopLeftX,
  output logic signed [10:0] bombTopLeftY,
  output logic               bombActive
);

  state_t             state;
  state_t             state_next;
  logic        [15:0] cooldown;
  logic        [2:0]  probe_col;
  logic        [2:0]  probe_count;
  logic signed [31:0] x_fixed;
  logic signed [31:0] y_fixed;
  logic signed [31:0] y_px;
  logic signed [31:0] spawn_x;
  logic signed [31:0] spawn_y;
  logic        [7:0]  lfsr_value;

  logic load_cooldown;
  logic tick_cooldown;
  logic enter_select;
  logic probe_fail;
  logic spawn;
  logic advance;

  lfsr8 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .value  (lfsr_value)
  );

  assign y_px    = y_fixed / FIXED_POINT_MULTIPLIER;
  assign spawn_x = {{21{aliensTopLeftX[10]}}, aliensTopLeftX}
                 + 32'(probe_col) * COLUMN_PITCH + BOMB_X_OFFSET;
  assign spawn_y = {{21{aliensTopLeftY[10]}}, aliensTopLeftY} + FORMATION_HEIGHT;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= Sidle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    load_cooldown = 1'b0;
    tick_cooldown = 1'b0;
    enter_select  = 1'b0;
    probe_fail    = 1'b0;
    spawn         = 1'b0;
    advance       = 1'b0;
    case (state)
      Sidle: begin
        if (enable) begin
          state_next    = Scooldown;
          load_cooldown = 1'b1;
        end
      end
      Scooldown: begin
        if (!enable) begin
          state_next = Sidle;
        end else if (cooldown == 16'd0) begin
          state_next   = Sselect;
          enter_select = 1'b1;
        end else if (startOfFrame) begin
          tick_cooldown = 1'b1;
        end
      end
      Sselect: begin
        if (!enable) begin
          state_next = Sidle;
        end else if (aliveColumns[probe_col]) begin
          state_next = Sfalling;
          spawn      = 1'b1;
        end else if (probe_count == 3'(NUM_COLUMNS - 1)) begin
          state_next    = Scooldown;
          load_cooldown = 1'b1;
        end else begin
          probe_fail = 1'b1;
        end
      end
      Sfalling: begin
        // A hit takes priority over a same-cycle frame tick, so Y is frozen at impact.
        if (bombHit || (y_px > BOTTOM_BOUNDARY)) begin
          if (enable) begin
            state_next    = Scooldown;
            load_cooldown = 1'b1;
          end else begin
            state_next = Sidle;
          end
        end else if (startOfFrame) begin
          advance = 1'b1;
        end
      end
      default: state_next = Sidle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cooldown    <= '0;
      probe_col   <= '0;
      probe_count <= '0;
      x_fixed     <= '0;
      y_fixed     <= '0;
    end else begin
      if (load_cooldown) begin
        cooldown <= 16'(COOLDOWN_FRAMES);
      end else if (tick_cooldown) begin
        cooldown <= cooldown - 16'd1;
      end
      if (enter_select) begin
        probe_col   <= 3'(lfsr_value % 8'(NUM_COLUMNS));
        probe_count <= '0;
      end else if (probe_fail) begin
        probe_col   <= probe_col + 3'd1;
        probe_count <= probe_count + 3'd1;
      end
      if (spawn) begin
        x_fixed <= spawn_x * FIXED_POINT_MULTIPLIER;
        y_fixed <= spawn_y * FIXED_POINT_MULTIPLIER;
      end else if (advance) begin
        y_fixed <= y_fixed + BOMB_SPEED;
      end
    end
  end

  assign bombActive   = (state == Sfalling);
  assign bombTopLeftX = 11'(x_fixed / FIXED_POINT_MULTIPLIER);
  assign bombTopLeftY = 11'(y_fixed / FIXED_POINT_MULTIPLIER);

endmodule

// File: tb/tb_alien_bomb_controller.sv
// tb/tb_alien_bomb_controller.sv - randomized directed bench with a frame-level reference model
module tb_alien_bomb_controller;

  localparam int COOL   = 45;
  localparam int PITCH  = 56;
  localparam int XOFF   = 24;
  localparam int HEIGHT = 160;
  localparam int BOTTOM = 479;
  localparam int STEP   = 2;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               enable;
  logic signed [10:0] aliensTopLeftX;
  logic signed [10:0] aliensTopLeftY;
  logic        [7:0]  aliveColumns;
  logic               bombHit;
  logic signed [10:0] bombTopLeftX;
  logic signed [10:0] bombTopLeftY;
  logic               bombActive;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] lfsr_m;
  int         ax;
  int         ay;
  int         ym;

  alien_bomb_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .enable         (enable),
    .aliensTopLeftX (aliensTopLeftX),
    .aliensTopLeftY (aliensTopLeftY),
    .aliveColumns   (aliveColumns),
    .bombHit        (bombHit),
    .bombTopLeftX   (bombTopLeftX),
    .bombTopLeftY   (bombTopLeftY),
    .bombActive     (bombActive)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; the model LFSR follows the generator's free-running sequence.
  task automatic tick();
    @(posedge clk);
    if (resetN === 1'b0) lfsr_m = 8'hA5;
    else                 lfsr_m = lfsr_step(lfsr_m);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      sof_pulse();
      tick();
    end
  endtask

  task automatic set_aliens(input int x, input int y);
    ax = x;
    ay = y;
    aliensTopLeftX = 11'(x);
    aliensTopLeftY = 11'(y);
  endtask

  // Call right after the cooldown was (re)loaded; a living column must exist.
  task automatic wait_spawn();
    int start;
    int col;
    int dead;
    frames(COOL - 1);
    chk("no_bomb_before_cooldown_end", bombActive, 0);
    sof_pulse();
    start = int'(lfsr_m[2:0]);
    col   = -1;
    dead  = 0;
    for (int i = 0; i < 8; i++) begin
      if (col < 0 && aliveColumns[(start + i) % 8]) begin
        col  = (start + i) % 8;
        dead = i;
      end
    end
    repeat (dead + 1) tick();
    chk("active_before_spawn", bombActive, 0);
    tick();
    ym = ay + HEIGHT;
    chk("active_at_spawn", bombActive, 1);
    chk("spawn_x", bombTopLeftX, ax + col * PITCH + XOFF);
    chk("spawn_y", bombTopLeftY, ym);
  endtask

  task automatic fall_to_bottom();
    forever begin
      sof_pulse();
      ym += STEP;
      if (ym > BOTTOM) break;
      tick();
    end
    chk("bottom_y_reached", bombTopLeftY, ym);
    chk("active_at_bottom", bombActive, 1);
    tick();
    chk("retired_after_bottom", bombActive, 0);
    chk("y_held_after_bottom", bombTopLeftY, ym);
  endtask

  task automatic hit_after(input int n, input logic with_sof);
    frames(n);
    ym += STEP * n;
    chk("y_before_hit", bombTopLeftY, ym);
    bombHit      = 1'b1;
    startOfFrame = with_sof;
    tick();
    bombHit      = 1'b0;
    startOfFrame = 1'b0;
    chk("retired_after_hit", bombActive, 0);
    chk("y_frozen_at_hit", bombTopLeftY, ym);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    enable       = 1'b0;
    bombHit      = 1'b0;
    aliveColumns = 8'hFF;
    set_aliens(40, 40);
    lfsr_m = 8'hA5;
    tick();
    tick();
    chk("reset_active", bombActive, 0);
    chk("reset_x", bombTopLeftX, 0);
    chk("reset_y", bombTopLeftY, 0);

    resetN = 1'b1;
    enable = 1'b1;
    tick();
    wait_spawn();
    frames(10);
    ym += STEP * 10;
    chk("y_after_10_frames", bombTopLeftY, 220);
    fall_to_bottom();

    aliveColumns = 8'h80;
    wait_spawn();
    chk("col7_x", bombTopLeftX, 456);
    chk("col7_y", bombTopLeftY, 200);
    hit_after(50, 1'b1);
    chk("hit_y_300", bombTopLeftY, 300);

    // Empty formation: a full probe sweep, with stray hits that must be ignored.
    aliveColumns = 8'h00;
    bombHit      = 1'b1;
    frames(COOL - 1);
    sof_pulse();
    repeat (9) begin
      tick();
      chk("no_bomb_empty_formation", bombActive, 0);
    end
    bombHit      = 1'b0;
    aliveColumns = 8'($urandom_range(1, 255));
    set_aliens(int'($urandom_range(0, 300)) - 100, int'($urandom_range(0, 200)));
    wait_spawn();

    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 1) == 0) fall_to_bottom();
      else hit_after(int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      aliveColumns = 8'($urandom_range(1, 255));
      set_aliens(int'($urandom_range(0, 300)) - 100, int'($urandom_range(0, 200)));
      wait_spawn();
    end

    // Dropping enable mid-cooldown restarts the full cooldown on re-enable.
    hit_after(3, 1'b0);
    frames(20);
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    wait_spawn();

    enable = 1'b0;
    fall_to_bottom();
    frames(COOL + 5);
    chk("idle_no_bomb", bombActive, 0);
    enable = 1'b1;
    tick();
    wait_spawn();

    frames(5);
    resetN = 1'b0;
    tick();
    chk("midfall_reset_active", bombActive, 0);
    chk("midfall_reset_x", bombTopLeftX, 0);
    chk("midfall_reset_y", bombTopLeftY, 0);
    resetN = 1'b1;
    tick();
    wait_spawn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alien_bomb_controller.md
ALIEN_BOMB_CONTROLLER -- requirements
Module: alien_bomb_controller

Interface
REQ-001 Parameter COOLDOWN_FRAMES, 45, frames between a bomb ending and the next column selection.
REQ-002 Parameter BOMB_SPEED, 128, fixed-point Y increment per frame (2 px at x64).
REQ-003 Parameter COLUMN_PITCH, 56, pixel distance between formation columns.
REQ-004 Parameter BOMB_X_OFFSET, 24, pixel offset of the bomb inside its column.
REQ-005 Parameter FORMATION_HEIGHT, 160, pixel offset from formation top to the bomb spawn row.
REQ-006 Parameter BOTTOM_BOUNDARY, 479, pixel Y beyond which the bomb is retired.
REQ-007 clk  in  1  system clock; the only clock.
REQ-008 resetN  in  1  reset; synchronous, active-low.
REQ-009 startOfFrame  in  1  one-clk pulse per frame, 30 Hz.
REQ-010 enable  in  1  game running; permits new bombs.
REQ-011 aliensTopLeftX  in  signed 11  formation top-left X, pixels.
REQ-012 aliensTopLeftY  in  signed 11  formation top-left Y, pixels.
REQ-013 aliveColumns  in  8  bit i set = column i has a living alien.
REQ-014 bombHit  in  1  collision of the bomb with player/shield.
REQ-015 bombTopLeftX  out  signed 11  bomb X, pixels.
REQ-016 bombTopLeftY  out  signed 11  bomb Y, pixels.
REQ-017 bombActive  out  1  bomb exists; drawing request.

Function
REQ-018 FSM states SHALL be Sidle, Scooldown, Sselect, Sfalling; state register updates on every clk rising edge.
REQ-019 Sidle -> Scooldown when enable=1; cooldown counter loaded with COOLDOWN_FRAMES on entry.
REQ-020 In Scooldown the counter SHALL decrement on each startOfFrame; at 0 -> Sselect (COOLDOWN_FRAMES=0 -> Sselect on the next clk).
REQ-021 On entering Sselect, the probe column SHALL be loaded from lfsr[2:0] and a 3-bit probe count cleared.
REQ-022 Sselect SHALL test one column per clk; if aliveColumns[col]=1, spawn and -> Sfalling; else col increments mod 8 (7 wraps to 0).
REQ-023 After 8 failed probes Sselect -> Scooldown with counter reloaded; no bomb spawned.
REQ-024 Spawn SHALL load X = aliensTopLeftX + col*COLUMN_PITCH + BOMB_X_OFFSET and Y = aliensTopLeftY + FORMATION_HEIGHT, both stored x64 fixed-point (32-bit signed).
REQ-025 In Sfalling, Y fixed-point SHALL increase by BOMB_SPEED per startOfFrame; X constant.
REQ-026 Sfalling -> Scooldown (counter reloaded) when bombHit=1, or when Y pixel > BOTTOM_BOUNDARY.
REQ-027 bombHit and startOfFrame in the same clk: hit wins, Y not advanced.
REQ-028 bombHit outside Sfalling SHALL be ignored.
REQ-029 enable=0 in Scooldown or Sselect -> Sidle next clk; a bomb in Sfalling completes normally, then -> Sidle if enable=0 at exit.
REQ-030 bombActive SHALL be 1 exactly while state is Sfalling (first asserted the clk after the spawning Sselect cycle).
REQ-031 bombTopLeftX/Y SHALL equal fixed-point / 64; they hold last value outside Sfalling.
REQ-032 An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) SHALL advance every clk.

Reset
REQ-033 resetN=0 at a clk edge SHALL force Sidle, counter 0, fixed-point X/Y 0, LFSR 8'hA5.
REQ-034 Output reset values: bombTopLeftX=0, bombTopLeftY=0, bombActive=0, effective the same edge, including mid-fall.

Structure
REQ-035 State enum, FIXED_POINT_MULTIPLIER=64 and NUM_COLUMNS=8 SHALL live in shared package aliens_pkg.
REQ-036 The LFSR SHALL be a sub-module lfsr8 (clk, resetN, 8-bit value out).

Verification
REQ-037 enable=1, aliveColumns=8'hFF, aliens (40,40): after 45 startOfFrame pulses, bombActive=1 within 2 clks, X=40+col*56+24, Y=200.
REQ-038 Falling bomb, 10 startOfFrame pulses -> Y rises 20 px; Y reaching 480 -> bombActive=0 next clk, cooldown reloaded to 45.
REQ-039 aliveColumns=8'h00 -> 8 probe clks, bombActive stays 0, back in Scooldown with counter 45.
REQ-040 aliveColumns=8'h80, aliens (40,40) -> bomb X=456, Y=200 for any LFSR value.
REQ-041 bombHit with startOfFrame same clk at Y=300 -> Y stays 300, bombActive=0 next clk.
REQ-042 resetN=0 for one clk during Sfalling -> all outputs 0 at that edge, state Sidle; new bomb only after 45 frames.
